// File: rtl/dnn_result_uart_tx_pkg.sv
// Shared definitions for the DNN result UART byte streamer:
// ASCII class codes, TX FSM states and the result-counter width helper.
package dnn_result_uart_tx_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NONE  = 8'h3F;
    localparam logic [7:0] CH_MULTI = 8'h2A;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        TERM,
        DONE
    } tx_state_t;

    // Counter must still be at least one bit wide when no results are expected.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dnn_result_uart_tx_if.sv
// Byte interface between the result streamer (master) and the UART transmitter (slave).
interface dnn_result_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/dnn_result_uart_tx_byte_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_10MHz_buf,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_10MHz_buf or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_10MHz_buf) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dnn_result_uart_tx.sv
// Captures DNN output activations, encodes each as an ASCII class byte,
// queues them and streams them to the UART, ending with a terminator byte.
module dnn_result_uart_tx
    import dnn_result_uart_tx_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned NUM_RESULTS = 200,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  TERM_BYTE   = 8'h0A
) (
    input  logic                                 clk_10MHz_buf,
    input  logic                                 resetn,
    input  logic                                 clear,
    input  logic                                 res_valid,
    input  logic [NUM_CLASSES-1:0]               res_act,
    dnn_result_uart_tx_if.master                 uart,
    output logic [cnt_width(NUM_RESULTS)-1:0]    result_count,
    output logic [3:0]                           last_class,
    output logic                                 overflow,
    output logic                                 done
);
    localparam int unsigned     CW      = cnt_width(NUM_RESULTS);
    localparam logic [CW-1:0]   RES_MAX = CW'(NUM_RESULTS);

    tx_state_t  state;
    logic [1:0] wait_cnt;
    logic       term;
    logic [7:0] enc_byte;
    logic [3:0] enc_class;
    logic       hit;
    logic       accept;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;

    always_comb begin
        enc_class = 4'hF;
        enc_byte  = CH_NONE;
        hit       = 1'b0;
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            if (res_act[i] && !hit) begin
                enc_class = 4'(i);
                hit       = 1'b1;
            end
        end
        if ($countones(res_act) == 1)     enc_byte = CH_ZERO + {4'h0, enc_class};
        else if ($countones(res_act) > 1) enc_byte = CH_MULTI;
    end

    assign accept = res_valid && (result_count < RES_MAX);
    assign pop    = (state == IDLE) && !fifo_empty && !uart.tx_busy;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_10MHz_buf (clk_10MHz_buf),
        .resetn        (resetn),
        .clear         (clear),
        .push          (accept),
        .push_data     (enc_byte),
        .pop           (pop),
        .pop_data      (fifo_head),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

    always_ff @(posedge clk_10MHz_buf or negedge resetn) begin
        if (!resetn) begin
            result_count <= '0;
            last_class   <= 4'hF;
            overflow     <= 1'b0;
        end else if (clear) begin
            result_count <= '0;
            last_class   <= 4'hF;
            overflow     <= 1'b0;
        end else if (accept) begin
            result_count <= result_count + 1'b1;
            last_class   <= enc_class;
            // A same-cycle pop frees the slot, so only a stalled full FIFO drops.
            if (fifo_full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_10MHz_buf or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            uart.tx_data  <= '0;
            uart.tx_start <= 1'b0;
            done          <= 1'b0;
            term          <= 1'b0;
            wait_cnt      <= '0;
        end else if (clear) begin
            state         <= IDLE;
            uart.tx_data  <= '0;
            uart.tx_start <= 1'b0;
            done          <= 1'b0;
            term          <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && !uart.tx_busy) begin
                        uart.tx_data  <= fifo_head;
                        uart.tx_start <= 1'b1;
                        term          <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= START;
                    end else if (fifo_empty && result_count == RES_MAX) begin
                        uart.tx_data  <= TERM_BYTE;
                        uart.tx_start <= 1'b1;
                        term          <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= TERM;
                    end
                end
                START, TERM: begin
                    uart.tx_start <= 1'b0;
                    state         <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (uart.tx_busy || wait_cnt == 2'd3) state <= WAIT_LO;
                    else                                  wait_cnt <= wait_cnt + 2'd1;
                end
                WAIT_LO: begin
                    if (!uart.tx_busy) begin
                        if (term) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_result_uart_tx.sv
// Directed/randomised bench for dnn_result_uart_tx with a queue-based byte model.
module tb_dnn_result_uart_tx;

    logic       clk_10MHz_buf;
    logic       resetn;
    logic       clear;
    logic       res_valid;
    logic [9:0] res_act;
    logic [7:0] result_count;
    logic [3:0] last_class;
    logic       overflow;
    logic       done;

    logic       res_valid4;
    logic [9:0] res_act4;
    logic [2:0] result_count4;
    logic [3:0] last_class4;
    logic       overflow4;
    logic       done4;

    dnn_result_uart_tx_if uif ();
    dnn_result_uart_tx_if uif4 ();

    dnn_result_uart_tx dut (
        .clk_10MHz_buf (clk_10MHz_buf),
        .resetn        (resetn),
        .clear         (clear),
        .res_valid     (res_valid),
        .res_act       (res_act),
        .uart          (uif),
        .result_count  (result_count),
        .last_class    (last_class),
        .overflow      (overflow),
        .done          (done)
    );

    dnn_result_uart_tx #(.NUM_RESULTS(4)) dut4 (
        .clk_10MHz_buf (clk_10MHz_buf),
        .resetn        (resetn),
        .clear         (clear),
        .res_valid     (res_valid4),
        .res_act       (res_act4),
        .uart          (uif4),
        .result_count  (result_count4),
        .last_class    (last_class4),
        .overflow      (overflow4),
        .done          (done4)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          mode = 0;          // 0 normal transmitter, 1 busy held, 2 never busy
    int          busy_cnt = 0;
    int          busy_cnt4 = 0;
    bit          hold_ok = 0;
    logic [7:0]  last_sent;
    logic [7:0]  rx[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx4[$];
    logic [7:0]  exp4[$];
    int unsigned exp_count = 0;

    initial clk_10MHz_buf = 1'b0;
    always #50 clk_10MHz_buf = ~clk_10MHz_buf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model and byte monitor for the main instance.
    always @(negedge clk_10MHz_buf) begin
        if (!resetn) hold_ok = 0;
        if (uif.tx_start) begin
            rx.push_back(uif.tx_data);
            last_sent = uif.tx_data;
            hold_ok   = 1;
        end else if (hold_ok && uif.tx_busy && resetn) begin
            chk("tx_data_hold", {24'h0, uif.tx_data}, {24'h0, last_sent});
        end
        if (mode == 0) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                uif.tx_busy = (busy_cnt != 0);
            end else if (uif.tx_start) begin
                uif.tx_busy = 1'b1;
                busy_cnt    = 8;
            end else begin
                uif.tx_busy = 1'b0;
            end
        end else if (mode == 1) begin
            uif.tx_busy = 1'b1;
        end else begin
            uif.tx_busy = 1'b0;
        end
        if (!uif.tx_busy) hold_ok = 0;
    end

    always @(negedge clk_10MHz_buf) begin
        if (uif4.tx_start) rx4.push_back(uif4.tx_data);
        if (busy_cnt4 > 0) begin
            busy_cnt4--;
            uif4.tx_busy = (busy_cnt4 != 0);
        end else if (uif4.tx_start) begin
            uif4.tx_busy = 1'b1;
            busy_cnt4    = 6;
        end else begin
            uif4.tx_busy = 1'b0;
        end
    end

    function automatic logic [7:0] model_byte(input logic [9:0] a);
        int n = $countones(a);
        if (n == 0) return 8'h3F;
        if (n > 1)  return 8'h2A;
        for (int i = 0; i < 10; i++) if (a[i]) return 8'h30 + 8'(i);
        return 8'h00;
    endfunction

    function automatic logic [3:0] model_class(input logic [9:0] a);
        for (int i = 0; i < 10; i++) if (a[i]) return 4'(i);
        return 4'hF;
    endfunction

    function automatic logic [9:0] rand_act();
        logic [9:0] one = 10'd1;
        case ($urandom_range(0, 3))
            0:       return 10'd0;
            3:       return 10'($urandom);
            default: return one << $urandom_range(0, 9);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_10MHz_buf);
        #1;
    endtask

    task automatic strobe(input logic [9:0] act, input bit keep);
        res_act   = act;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        exp_count++;
        chk("result_count", {24'h0, result_count}, exp_count);
        chk("last_class", {28'h0, last_class}, {28'h0, model_class(act)});
        if (keep) exp_q.push_back(model_byte(act));
    endtask

    task automatic settle(input string tag);
        int unsigned n = 0;
        while (rx.size() < exp_q.size() && n < 2000) begin
            tick();
            n++;
        end
        repeat (20) tick();
        chk({tag, "_nbytes"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < rx.size()) ? {24'h0, rx[i]} : 32'hDEAD, {24'h0, exp_q[i]});
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [9:0] a;
        int unsigned n;
        resetn     = 1'b0;
        clear      = 1'b0;
        res_valid  = 1'b0;
        res_act    = '0;
        res_valid4 = 1'b0;
        res_act4   = '0;
        repeat (3) tick();
        chk("rst_tx_data", {24'h0, uif.tx_data}, 32'h0);
        chk("rst_tx_start", {31'h0, uif.tx_start}, 32'h0);
        chk("rst_count", {24'h0, result_count}, 32'h0);
        chk("rst_last_class", {28'h0, last_class}, 32'hF);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        resetn = 1'b1;
        repeat (3) tick();

        // First byte: single pulse two cycles after the strobe.
        strobe(10'b0000001000, 1);
        chk("tx_start_plus1", {31'h0, uif.tx_start}, 32'h0);
        tick();
        chk("tx_start_plus2", {31'h0, uif.tx_start}, 32'h1);
        chk("tx_data_plus2", {24'h0, uif.tx_data}, 32'h33);
        tick();
        chk("tx_start_pulse", {31'h0, uif.tx_start}, 32'h0);
        settle("first_byte");

        strobe(10'b0000000000, 1);
        repeat (15) tick();
        strobe(10'b0000100100, 1);
        settle("none_multi");

        // NUM_RESULTS=4 instance: fifth strobe ignored, then terminator and done.
        for (int i = 0; i < 5; i++) begin
            a          = rand_act();
            res_act4   = a;
            res_valid4 = 1'b1;
            tick();
            res_valid4 = 1'b0;
            chk("count4", {29'h0, result_count4}, (i < 4) ? i + 1 : 4);
            if (i < 4) exp4.push_back(model_byte(a));
            repeat (20) tick();
        end
        n = 0;
        while (!done4 && n < 500) begin
            tick();
            n++;
        end
        chk("done4", {31'h0, done4}, 32'h1);
        exp4.push_back(8'h0A);
        repeat (50) tick();
        chk("rx4_nbytes", rx4.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rx4_byte", (i < rx4.size()) ? {24'h0, rx4[i]} : 32'hDEAD, {24'h0, exp4[i]});
        chk("done4_held", {31'h0, done4}, 32'h1);

        for (int i = 0; i < 30; i++) begin
            strobe(rand_act(), 1);
            repeat ($urandom_range(15, 20)) tick();
        end
        settle("random");

        // Overflow: transmitter stalled while 20 results arrive.
        mode = 1;
        repeat (2) tick();
        for (int i = 0; i < 20; i++) begin
            strobe(rand_act(), i < 16);
            repeat (49) tick();
        end
        chk("ovf_flag", {31'h0, overflow}, 32'h1);
        chk("ovf_no_tx", rx.size(), 0);
        mode = 0;
        settle("overflow_drain");
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Synchronous clear beats a same-cycle strobe.
        res_act   = 10'b0000000001;
        res_valid = 1'b1;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        res_valid = 1'b0;
        exp_count = 0;
        chk("clr_count", {24'h0, result_count}, 32'h0);
        chk("clr_last_class", {28'h0, last_class}, 32'hF);
        chk("clr_overflow", {31'h0, overflow}, 32'h0);
        chk("clr_done4", {31'h0, done4}, 32'h0);
        repeat (20) tick();
        chk("clr_no_tx", rx.size(), 0);

        // Transmitter that never asserts busy.
        mode = 2;
        for (int i = 0; i < 5; i++) begin
            strobe(rand_act(), 1);
            repeat (12) tick();
        end
        settle("never_busy");
        mode = 0;
        repeat (3) tick();

        // Asynchronous reset while waiting for busy to fall.
        strobe(rand_act(), 0);
        n = 0;
        while (!uif.tx_busy && n < 20) begin
            tick();
            n++;
        end
        chk("busy_seen", {31'h0, uif.tx_busy}, 32'h1);
        repeat (2) tick();
        #10 resetn = 1'b0;
        #1;
        chk("mid_tx_data", {24'h0, uif.tx_data}, 32'h0);
        chk("mid_tx_start", {31'h0, uif.tx_start}, 32'h0);
        chk("mid_count", {24'h0, result_count}, 32'h0);
        chk("mid_last_class", {28'h0, last_class}, 32'hF);
        chk("mid_done", {31'h0, done}, 32'h0);
        tick();
        resetn = 1'b1;
        rx.delete();
        exp_count = 0;
        repeat (15) tick();
        strobe(10'b1000000000, 1);
        settle("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
